// File: rtl/ir_scan_engine_if.sv
// ---------------------------------------------------------------------------
// ir_scan_engine_if : result stream (valid/ready) carrying one rx count per beat
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ir_scan_engine_if #(
  parameter int kTxCount   = 12,
  parameter int kRxCount   = 20,
  parameter int kCountBits = 20
);
  localparam int kTxW = (kTxCount > 1) ? $clog2(kTxCount) : 1;
  localparam int kRxW = (kRxCount > 1) ? $clog2(kRxCount) : 1;

  logic                  res_valid;
  logic                  res_ready;
  logic [kTxW-1:0]       res_tx;
  logic [kRxW-1:0]       res_rx;
  logic [kCountBits-1:0] res_count;
  logic                  res_last;

  modport master (
    output res_valid, res_tx, res_rx, res_count, res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_tx, res_rx, res_count, res_last,
    output res_ready
  );
endinterface

`default_nettype wire

// File: rtl/ir_scan_engine.sv
// ---------------------------------------------------------------------------
// ir_scan_engine : time-multiplexed IR emitter scan with per-receiver pulse
//                  counting and a per-slot result streamer.
// Option macro   : IR_SCAN_RX_SYNC_EN (two-flop synchronizer on ir_rx)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ir_scan_engine #(
  parameter int kHalfPeriodClocks = 329,
  parameter int kBurstHalves      = 1520,
  parameter int kRepeatHalves     = 2280,
  parameter int kMaskHalves       = 380,
  parameter int kTxCount          = 12,
  parameter int kRxCount          = 20,
  parameter int kCountBits        = 20
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                run,
  input  wire logic [kTxCount-1:0] tx_enable,
  input  wire logic [kRxCount-1:0] ir_rx,
  output logic      [kTxCount-1:0] ir_tx,
  output logic      [7:0]          overrun_count,
  ir_scan_engine_if.master         res
);

  localparam int kTxW   = (kTxCount > 1) ? $clog2(kTxCount) : 1;
  localparam int kRxW   = (kRxCount > 1) ? $clog2(kRxCount) : 1;
  localparam int kModW  = $clog2(kHalfPeriodClocks + 1);
  localparam int kSlotW = $clog2(kRepeatHalves + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  logic [kModW-1:0]                      mod_cnt_q, mod_cnt_d;
  logic                                  mod_state_q, mod_state_d;
  logic [kSlotW-1:0]                     slot_q, slot_d;
  logic [kTxW-1:0]                       cur_tx_q, cur_tx_d;
  logic [kTxCount-1:0]                   ir_tx_q, ir_tx_d;
  logic [kRxCount-1:0][kCountBits-1:0]   cnt_q, cnt_d, cnt_upd;
  logic [kRxCount-1:0][kCountBits-1:0]   lat_q, lat_d;
  logic [kTxW-1:0]                       lat_tx_q, lat_tx_d;
  logic [kRxW-1:0]                       rx_idx_q, rx_idx_d;
  logic [7:0]                            ovr_q, ovr_d;
  state_t                                state_q, state_d;
  logic                                  half_edge, slot_end;
  logic [kRxCount-1:0]                   rx_s;

`ifdef IR_SCAN_RX_SYNC_EN
  logic [kRxCount-1:0] rx_sync1_q, rx_sync2_q;

  // Detectors idle high, so the synchronizer resets to "no light".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= '1;
      rx_sync2_q <= '1;
    end else begin
      rx_sync1_q <= ir_rx;
      rx_sync2_q <= rx_sync1_q;
    end
  end
  assign rx_s = rx_sync2_q;
`else
  assign rx_s = ir_rx;
`endif

  assign half_edge = run && (mod_cnt_q == kModW'(kHalfPeriodClocks - 1));
  assign slot_end  = half_edge && (slot_q == kSlotW'(kRepeatHalves - 1));

  always_comb begin
    mod_cnt_d   = mod_cnt_q;
    mod_state_d = mod_state_q;
    slot_d      = slot_q;
    cur_tx_d    = cur_tx_q;
    ir_tx_d     = '0;
    if (!run) begin
      mod_cnt_d   = '0;
      mod_state_d = 1'b0;
      slot_d      = '0;
      cur_tx_d    = '0;
    end else begin
      mod_cnt_d = half_edge ? '0 : mod_cnt_q + kModW'(1);
      if (half_edge) begin
        mod_state_d = ~mod_state_q;
      end
      if (slot_end) begin
        slot_d   = '0;
        cur_tx_d = (cur_tx_q == kTxW'(kTxCount - 1)) ? '0 : cur_tx_q + kTxW'(1);
      end else if (half_edge) begin
        slot_d = slot_q + kSlotW'(1);
      end
      // A disabled transmitter keeps its slot dark: ambient baseline.
      if ((slot_q < kSlotW'(kBurstHalves)) && mod_state_q && tx_enable[cur_tx_q]) begin
        ir_tx_d[cur_tx_q] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_upd = cnt_q;
    cnt_d   = '0;
    for (int i = 0; i < kRxCount; i++) begin
      if (run && (slot_q >= kSlotW'(kMaskHalves)) && !rx_s[i] && !(&cnt_q[i])) begin
        cnt_upd[i] = cnt_q[i] + kCountBits'(1);
      end
      cnt_d[i] = (!run || slot_end) ? '0 : cnt_upd[i];
    end
  end

  // The latch captures this clock's update so the slot's last clock is counted.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    lat_tx_d = lat_tx_q;
    rx_idx_d = rx_idx_q;
    ovr_d    = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (slot_end) begin
          lat_d    = cnt_upd;
          lat_tx_d = cur_tx_q;
          rx_idx_d = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (slot_end && (ovr_q != 8'hFF)) begin
          ovr_d = ovr_q + 8'd1;
        end
        if (res.res_ready) begin
          if (rx_idx_q == kRxW'(kRxCount - 1)) begin
            state_d = ST_IDLE;
          end else begin
            rx_idx_d = rx_idx_q + kRxW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_cnt_q   <= '0;
      mod_state_q <= 1'b0;
      slot_q      <= '0;
      cur_tx_q    <= '0;
      ir_tx_q     <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      lat_tx_q    <= '0;
      rx_idx_q    <= '0;
      ovr_q       <= '0;
      state_q     <= ST_IDLE;
    end else begin
      mod_cnt_q   <= mod_cnt_d;
      mod_state_q <= mod_state_d;
      slot_q      <= slot_d;
      cur_tx_q    <= cur_tx_d;
      ir_tx_q     <= ir_tx_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      lat_tx_q    <= lat_tx_d;
      rx_idx_q    <= rx_idx_d;
      ovr_q       <= ovr_d;
      state_q     <= state_d;
    end
  end

  assign ir_tx         = ir_tx_q;
  assign overrun_count = ovr_q;
  assign res.res_valid = (state_q == ST_SEND);
  assign res.res_tx    = lat_tx_q;
  assign res.res_rx    = rx_idx_q;
  assign res.res_count = lat_q[rx_idx_q];
  assign res.res_last  = (state_q == ST_SEND) && (rx_idx_q == kRxW'(kRxCount - 1));

endmodule

`default_nettype wire

// File: tb/tb_ir_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_ir_scan_engine : scoreboard bench for ir_scan_engine (count widths 4 and 3)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ir_scan_engine;

  localparam int kHalf   = 2;
  localparam int kBurst  = 4;
  localparam int kRepeat = 6;
  localparam int kMask   = 1;
  localparam int kSlotClk = kHalf * kRepeat;

  typedef struct {
    logic [1:0] tx;
    logic       rx;
    logic [3:0] cnt;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n, run, ready;
  logic [2:0] tx_enable, ir_tx, ir_tx3;
  logic [1:0] ir_rx;
  logic [7:0] ovr, ovr3;

  int n_vec = 0;
  int n_bad = 0;

  beat_t q4[$];
  beat_t q3[$];
  int    t = 0;
  int    m_cnt[2];
  logic [1:0] rx_d1, rx_d2, rx_eff;
  logic [2:0] exp_ir = '0;
  int    exp_ovr = 0;
  int    exp_ovr3 = 0;

  always #5 clk = ~clk;

  ir_scan_engine_if #(.kTxCount(3), .kRxCount(2), .kCountBits(4)) res_if ();
  ir_scan_engine_if #(.kTxCount(3), .kRxCount(2), .kCountBits(3)) res3_if ();

  assign res_if.res_ready  = ready;
  assign res3_if.res_ready = 1'b1;

  ir_scan_engine #(
    .kHalfPeriodClocks(kHalf), .kBurstHalves(kBurst), .kRepeatHalves(kRepeat),
    .kMaskHalves(kMask), .kTxCount(3), .kRxCount(2), .kCountBits(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tx_enable(tx_enable), .ir_rx(ir_rx),
    .ir_tx(ir_tx), .overrun_count(ovr), .res(res_if)
  );

  ir_scan_engine #(
    .kHalfPeriodClocks(kHalf), .kBurstHalves(kBurst), .kRepeatHalves(kRepeat),
    .kMaskHalves(kMask), .kTxCount(3), .kRxCount(2), .kCountBits(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .run(run), .tx_enable(tx_enable), .ir_rx(ir_rx),
    .ir_tx(ir_tx3), .overrun_count(ovr3), .res(res3_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: evaluated on the falling edge for the next rising edge.
  always @(negedge clk) begin
    logic busy4, busy3;
    logic [2:0] nxt;
    int cs, half, txi;
    if (!rst_n) begin
      check_eq("rst_valid", {31'd0, res_if.res_valid}, 0);
      check_eq("rst_valid3", {31'd0, res3_if.res_valid}, 0);
      check_eq("rst_ovr", {24'd0, ovr}, 0);
      check_eq("rst_ir_tx", {29'd0, ir_tx}, 0);
      q4.delete();
      q3.delete();
      t = 0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      rx_d1 = '1;
      rx_d2 = '1;
      exp_ir = '0;
      exp_ovr = 0;
      exp_ovr3 = 0;
    end else begin
      check_eq("ir_tx", {29'd0, ir_tx}, {29'd0, exp_ir});
      check_eq("ir_tx_w3", {29'd0, ir_tx3}, {29'd0, exp_ir});
      check_eq("overrun", {24'd0, ovr}, exp_ovr);
      check_eq("overrun_w3", {24'd0, ovr3}, exp_ovr3);
      check_eq("res_valid", {31'd0, res_if.res_valid}, (q4.size() != 0) ? 1 : 0);
      check_eq("res_valid_w3", {31'd0, res3_if.res_valid}, (q3.size() != 0) ? 1 : 0);
      if (q4.size() != 0) begin
        check_eq("res_beat", {22'd0, res_if.res_tx, res_if.res_rx, res_if.res_count, res_if.res_last},
                 {22'd0, q4[0].tx, q4[0].rx, q4[0].cnt, q4[0].last});
      end
      if (q3.size() != 0) begin
        check_eq("res_beat_w3", {22'd0, res3_if.res_tx, res3_if.res_rx, 1'b0, res3_if.res_count, res3_if.res_last},
                 {22'd0, q3[0].tx, q3[0].rx, q3[0].cnt, q3[0].last});
      end
`ifdef IR_SCAN_RX_SYNC_EN
      rx_eff = rx_d2;
      rx_d2  = rx_d1;
      rx_d1  = ir_rx;
`else
      rx_eff = ir_rx;
`endif
      busy4 = (q4.size() != 0);
      busy3 = (q3.size() != 0);
      if (busy4 && ready) void'(q4.pop_front());
      if (busy3) void'(q3.pop_front());
      nxt = '0;
      if (run) begin
        cs   = t % kSlotClk;
        half = cs / kHalf;
        txi  = (t / kSlotClk) % 3;
        if (half < kBurst && (half % 2) == 1 && tx_enable[txi]) nxt[txi] = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (half >= kMask && !rx_eff[i]) m_cnt[i]++;
        end
        if (cs == kSlotClk - 1) begin
          if (!busy4) begin
            for (int i = 0; i < 2; i++)
              q4.push_back('{2'(txi), 1'(i), 4'((m_cnt[i] > 15) ? 15 : m_cnt[i]), (i == 1)});
          end else if (exp_ovr < 255) begin
            exp_ovr++;
          end
          if (!busy3) begin
            for (int i = 0; i < 2; i++)
              q3.push_back('{2'(txi), 1'(i), 4'((m_cnt[i] > 7) ? 7 : m_cnt[i]), (i == 1)});
          end else if (exp_ovr3 < 255) begin
            exp_ovr3++;
          end
          m_cnt[0] = 0;
          m_cnt[1] = 0;
        end
        t++;
      end else begin
        t = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end
      exp_ir = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < kSlotClk && (t % kSlotClk) != ph; k++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    ready = 1'b1;
    tx_enable = 3'b111;
    ir_rx = 2'b11;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Constant light on rx0 only.
    run = 1'b1;
    ir_rx = 2'b10;
    repeat (3 * kSlotClk) step();

    repeat (3 * kSlotClk) begin
      ir_rx = 2'($urandom_range(0, 3));
      step();
    end

    // Stall the consumer across two further slot ends.
    ir_rx = 2'b00;
    wait_phase(6);
    ready = 1'b0;
    repeat (30) step();
    check_eq("ovr_after_stall", {24'd0, ovr}, 2);
    ready = 1'b1;
    repeat (2 * kSlotClk) step();

    tx_enable = 3'b101;
    repeat (3 * kSlotClk) begin
      ir_rx = 2'($urandom_range(0, 3));
      step();
    end
    tx_enable = 3'b111;

    // Drop run while the emitter is lit.
    ir_rx = 2'b01;
    wait_phase(4);
    run = 1'b0;
    step();
    check_eq("ir_tx_after_drop", {29'd0, ir_tx}, 0);
    repeat (10) step();
    run = 1'b1;
    repeat (kSlotClk + 4) step();

    // Reset while a frame is held.
    wait_phase(6);
    ready = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    step();
    check_eq("valid_mid_reset", {31'd0, res_if.res_valid}, 0);
    ready = 1'b1;
    rst_n = 1'b1;
    repeat (30) step();
    check_eq("ovr_after_reset", {24'd0, ovr}, 0);

    run = 1'b0;
    for (int k = 0; k < 50 && (q4.size() != 0 || q3.size() != 0); k++) step();
    check_eq("drained", q4.size() + q3.size(), 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
